// File: rtl/img2col_window_packer.sv
// Consumer end of the img2col address stream: issues SRAM reads, captures the data one cycle
// later and packs K_R*K_S pixels into a window register, throttling the address source by credit.
module img2col_window_packer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int K_R    = 3,
   parameter int K_S    = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_async_n_i,
   input  logic                        addr_valid_i,
   output logic                        addr_ready_o,
   input  logic [ADDR_W-1:0]           addr_i,
   input  logic                        addr_last_i,
   output logic                        sram_rd_en_o,
   output logic [ADDR_W-1:0]           sram_rd_addr_o,
   input  logic [DATA_W-1:0]           sram_rd_data_i,
   output logic                        win_valid_o,
   input  logic                        win_ready_i,
   output logic [K_R*K_S*DATA_W-1:0]   win_data_o,
   output logic                        win_last_o,
   output logic                        frag_err_o
);

   localparam int KK    = K_R * K_S;
   localparam int CNT_W = $clog2(KK + 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(KK);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(KK - 1);

   logic [CNT_W-1:0]       fill_cnt;
   logic [CNT_W:0]         occupancy;
   logic                   inflight;
   logic                   last_q;
   logic [DATA_W-1:0]      lanes [KK];
   logic [KK*DATA_W-1:0]   next_win;
   logic                   held;
   logic                   complete;
   logic                   load;
   logic                   pop;
   logic                   credit;
   logic                   accept;

   // fill_cnt == KK means a finished window is parked waiting for the output register.
   assign held      = (fill_cnt == FULL_CNT);
   assign complete  = inflight & ((fill_cnt == LAST_LANE) | last_q);
   assign pop       = win_valid_o & win_ready_i;
   assign load      = (complete | held) & (~win_valid_o | win_ready_i);
   assign occupancy = {1'b0, fill_cnt} + {{CNT_W{1'b0}}, inflight};
   assign credit    = (occupancy < (CNT_W + 1)'(KK)) | (complete & load);

   assign addr_ready_o   = rst_async_n_i & credit;
   assign accept         = addr_valid_i & addr_ready_o;
   assign sram_rd_en_o   = accept;
   assign sram_rd_addr_o = addr_i;

   // Window image: earlier lanes, the pixel arriving now, and zeros above it for a short last window.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      next_win = '0;
      for (int n = 0; n < KK; n++) begin
         if (held || (CNT_W'(n) < fill_cnt)) begin
            next_win[n*DATA_W +: DATA_W] = lanes[n];
         end else if (CNT_W'(n) == fill_cnt) begin
            next_win[n*DATA_W +: DATA_W] = sram_rd_data_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (!rst_async_n_i) begin
         fill_cnt    <= '0;
         inflight    <= 1'b0;
         last_q      <= 1'b0;
         win_valid_o <= 1'b0;
         win_data_o  <= '0;
         win_last_o  <= 1'b0;
         frag_err_o  <= 1'b0;
      end else begin
         inflight <= accept;
         if (accept) begin
            last_q <= addr_last_i;
         end

         if (load) begin
            fill_cnt <= '0;
         end else if (complete) begin
            fill_cnt <= FULL_CNT;
         end else if (inflight) begin
            fill_cnt <= fill_cnt + 1'b1;
         end

         if (load) begin
            win_valid_o <= 1'b1;
            win_data_o  <= next_win;
            win_last_o  <= last_q;
         end else if (pop) begin
            win_valid_o <= 1'b0;
         end

         if (inflight && last_q && (fill_cnt < LAST_LANE)) begin
            frag_err_o <= 1'b1;
         end
      end
   end

   // NOTE: the assembly lanes carry no reset; fill_cnt alone decides which lanes are meaningful.
   always_ff @(posedge clk_i) begin
      if (inflight) begin
         for (int n = 0; n < KK; n++) begin
            lanes[n] <= next_win[n*DATA_W +: DATA_W];
         end
      end
   end

endmodule
